add_sub_seq_ctrl: RTL and testbench

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by time-multiplexing one shared 8-bit ripple/CLA adder slice (the `rca_cla_8` datapath), one byte per cycle, least-significant byte first. It owns operand capture, carry chaining between bytes, two's-complement operand inversion for subtract, and flag generation. It sits between an ALU-issue stage, which uses a valid/ready input handshake, and a result consumer, which uses a valid/ready output handshake.

---
 rtl/add_sub_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_add_sub_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq_ctrl.sv
// Byte-serial WIDTH-bit add/subtract sequencer driving one shared external 8-bit adder slice.
// Operands are captured on request; one byte is resolved per RUN cycle, LSB first.
module add_sub_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [7:0]       o_dp_a,
  output logic [7:0]       o_dp_b,
  output logic             o_dp_cin,
  input  logic [7:0]       i_dp_sum,
  input  logic             i_dp_cout
);

  localparam int N    = int'(WIDTH / 8);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_last;
  logic             w_run;

  // Byte select and result merge for the current step.
  always_comb begin
    w_a_byte     = '0;
    w_b_byte     = '0;
    w_result_nxt = r_result;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_byte                 = r_a[8*k +: 8];
        w_b_byte                 = r_b[8*k +: 8];
        w_result_nxt[8*k +: 8]   = i_dp_sum;
      end
    end
  end

  assign w_last = (r_idx == IDXW'(N - 1));
  assign w_run  = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            // Subtract as A + ~B + 1: invert B here, inject the +1 as the first carry.
            r_a     <= i_a;
            r_b     <= i_mode ? ~i_b : i_b;
            r_carry <= i_mode;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_nxt;
          r_carry  <= i_dp_cout;
          if (w_last) begin
            r_cout  <= i_dp_cout;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (i_dp_sum[7] != r_a[WIDTH-1]);
            r_zero  <= (w_result_nxt == '0);
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;
  assign o_dp_a      = w_run ? w_a_byte : 8'h00;
  assign o_dp_b      = w_run ? w_b_byte : 8'h00;
  assign o_dp_cin    = w_run & r_carry;

endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Scoreboard bench for add_sub_seq_ctrl: the issue task queues hand-computed results,
// a negedge monitor pops and compares on every out_valid/out_ready handshake.
module tb_add_sub_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic [7:0]   dp_a;
  logic [7:0]   dp_b;
  logic         dp_cin;
  logic [7:0]   dp_sum;
  logic         dp_cout;
  logic [8:0]   dp_full;

  always #5 clk = ~clk;

  // Behavioural model of the shared 8-bit adder slice.
  assign dp_full = {1'b0, dp_a} + {1'b0, dp_b} + {8'b0, dp_cin};
  assign dp_sum  = dp_full[7:0];
  assign dp_cout = dp_full[8];

  add_sub_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a_in),
    .i_b         (b_in),
    .i_mode      (mode),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_cout      (cout),
    .o_ovf       (ovf),
    .o_zero      (zero),
    .o_dp_a      (dp_a),
    .o_dp_b      (dp_b),
    .o_dp_cin    (dp_cin),
    .i_dp_sum    (dp_sum),
    .i_dp_cout   (dp_cout)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_accept = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Present a request until accepted; optionally queue its expected response.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [W-1:0] er, input logic ec, input logic ev,
                       input logic ez, input bit push);
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    mode     = m;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_within_bound", 32'(waitc < 200), 32'd1);
    @(posedge clk);
    #1;
    last_accept = cyc;
    in_valid    = 1'b0;
    if (push) sb.push_back('{r: er, c: ec, v: ev, z: ez});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: result %h with empty scoreboard", result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.r);
        check("cout", 32'(cout), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    int hs_set;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    check("rst_dp", 32'({dp_a, dp_b, dp_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);

    // out_valid must rise exactly on the 4th edge after acceptance.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("latency_early", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check("latency_on_time", 32'(out_valid), 32'd1);

    issue(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(32'd5, 32'd5, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold the result in DONE while junk requests toggle.
    issue(32'h0000_1234, 32'h0000_0034, 1'b1, 32'h0000_1200, 1'b1, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    check("stall_done_reached", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a_in     = $urandom;
      b_in     = $urandom;
      mode     = ~mode;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result", result, 32'h0000_1200);
      check("stall_flags", 32'({cout, ovf, zero}), 32'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hs_set    = cyc;
    issue(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    // Handshake edge is hs_set+1; the earliest accept is the edge after it.
    check("accept_after_release", 32'(last_accept - hs_set), 32'd2);

    // Abort an operation mid-RUN with an asynchronous reset.
    issue(32'hAAAA_0000, 32'h0000_5555, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("run_dp_a_byte2", 32'(dp_a), 32'h0000_00AA);
    check("run_dp_b_byte2", 32'(dp_b), 32'h0000_0000);
    check("run_dp_cin_byte2", 32'(dp_cin), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", 32'({cout, ovf, zero}), 32'd0);
    check("abort_dp", 32'({dp_a, dp_b, dp_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_no_output", 32'(out_valid), 32'd0);
    end
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);

    waitc = 0;
    while (sb.size() != 0 && waitc < 100) begin
      @(posedge clk);
      waitc++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
